// File: rtl/slink_pulse_sched_pkg.sv
// Shared definitions for the slink pulse scheduler: FSM encoding and the
// index-width helper used for requester IDs and the gap counter.
package slink_pulse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Never returns 0, so a width derived from it is always legal.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/slink_pulse_sched_if.sv
// Requester-side and synchronizer-side signals of the pulse scheduler.
// The master drives events and control; the slave (the scheduler) returns pulses and status.
interface slink_pulse_sched_if #(
    parameter int NUM_REQ = 4
);
    import slink_pulse_sched_pkg::*;

    localparam int IW = id_w(NUM_REQ);

    logic               enable;
    logic [NUM_REQ-1:0] req_pulse;
    logic               ovf_clear;
    logic               pulse_out;
    logic [IW-1:0]      pulse_id;
    logic [NUM_REQ-1:0] ovf_sticky;
    logic               busy;

    modport master (
        output enable, req_pulse, ovf_clear,
        input  pulse_out, pulse_id, ovf_sticky, busy
    );

    modport slave (
        input  enable, req_pulse, ovf_clear,
        output pulse_out, pulse_id, ovf_sticky, busy
    );

endinterface

// File: rtl/slink_rr_arb.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping around, wins.
module slink_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt,
    output logic          gnt_vld
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt     = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/slink_pulse_sched.sv
// Per-requester event queue feeding one shared pulse synchronizer: saturating
// pending counters, round-robin selection and paced one-cycle pulses with a held ID.
//
// state | meaning
// IDLE  | no pulse in flight; issue as soon as enabled with any count pending
// ISSUE | pulse_out high for this single cycle; granted counter decrements
// HOLD  | pacing window, pulse_id held while the slow domain captures it
module slink_pulse_sched
    import slink_pulse_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CNT_W      = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    slink_pulse_sched_if.slave  bus
);

    localparam int               IW      = id_w(NUM_REQ);
    localparam int               GAP_W   = id_w(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [CNT_W-1:0]   cnt [NUM_REQ];
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] dec;
    logic [NUM_REQ-1:0] ovf_set;
    logic [NUM_REQ-1:0] ovf_q;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      gnt;
    logic [IW-1:0]      next_ptr;
    logic               gnt_vld;
    logic               issue_go;
    logic [GAP_W-1:0]   gap;
    logic               pulse_out_q;
    logic [IW-1:0]      pulse_id_q;

    always_comb begin
        pend    = '0;
        dec     = '0;
        ovf_set = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i]    = (cnt[i] != '0);
            dec[i]     = (state == ISSUE) && (pulse_id_q == IW'(i));
            ovf_set[i] = bus.req_pulse[i] && !dec[i] && (cnt[i] == CNT_MAX);
        end
    end

    slink_rr_arb #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req     (pend),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    assign next_ptr = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    assign issue_go = bus.enable && gnt_vld;

    // Same-cycle inc and dec cancel; an inc at max is dropped and flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_pulse[i] && !dec[i]) begin
                    if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
                end else if (!bus.req_pulse[i] && dec[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            ovf_q <= bus.ovf_clear ? '0 : (ovf_q | ovf_set);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            pulse_out_q <= 1'b0;
            pulse_id_q  <= '0;
            gap         <= '0;
        end else begin
            pulse_out_q <= 1'b0;
            case (state)
                ISSUE: begin
                    gap   <= GAP_W'(GAP_CYCLES - 2);
                    state <= HOLD;
                end
                IDLE, HOLD: begin
                    if (state == IDLE || gap == '0) begin
                        if (issue_go) begin
                            state       <= ISSUE;
                            pulse_out_q <= 1'b1;
                            pulse_id_q  <= gnt;
                            rr_ptr      <= next_ptr;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap <= gap - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pulse_out  = pulse_out_q;
    assign bus.pulse_id   = pulse_id_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.busy       = (state != IDLE) || (|pend);

endmodule
